// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The jump encodings mirror the decoder's jmp_pc field.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_OUT   = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_JAL  = 2'b01;
  localparam logic [1:0] JMP_JALR = 2'b10;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Combinational next-PC selection: decides whether resolved control info
// redirects fetch, and produces the word-aligned target and sequential PC.
module next_pc_sel
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ctrl_pc,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic [1:0]  jmp_pc,
  input  logic        b_pc,
  input  logic        branch_cond,
  input  logic        ctrl_valid,
  output logic        redirect,
  output logic [31:0] target,
  output logic [31:0] seq_pc,
  output logic        misaligned
);

  logic        is_jump;
  logic [31:0] raw_target;

  // Reserved jmp_pc encoding 2'b11 behaves like "no jump".
  always_comb begin
    is_jump    = 1'b0;
    raw_target = ctrl_pc + imm;
    case (jmp_pc)
      JMP_JAL:  is_jump = 1'b1;
      JMP_JALR: begin
        is_jump    = 1'b1;
        raw_target = alu_result & ~32'h1;
      end
      JMP_NONE: is_jump = 1'b0;
      default:  is_jump = 1'b0;
    endcase
    redirect   = ctrl_valid && (is_jump || (b_pc && branch_cond));
    target     = {raw_target[31:2], 2'b00};
    misaligned = raw_target[1:0] != 2'b00;
    seq_pc     = pc + 32'd4;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding word requests to imem and a
// valid/ready hand-off to the decoder, with control-flow redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        ctrl_valid,
  input  logic [31:0] ctrl_pc,
  input  logic [1:0]  jmp_pc,
  input  logic        b_pc,
  input  logic        branch_cond,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic        misalign_err
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  drain_addr, drain_addr_n;
  logic [31:0]  instr_n, instr_pc_n;
  logic         req_gap, req_gap_n;
  logic         redirect, misaligned;
  logic [31:0]  target, seq_pc;

  next_pc_sel u_next_pc_sel (
    .pc          (pc),
    .ctrl_pc     (ctrl_pc),
    .imm         (imm),
    .alu_result  (alu_result),
    .jmp_pc      (jmp_pc),
    .b_pc        (b_pc),
    .branch_cond (branch_cond),
    .ctrl_valid  (ctrl_valid),
    .redirect    (redirect),
    .target      (target),
    .seq_pc      (seq_pc),
    .misaligned  (misaligned)
  );

  // req_gap keeps imem_req low for one cycle: out of reset, and after a
  // response is dropped in REQ so the target goes out on a fresh request.
  assign imem_req    = ((state == S_REQ) && !req_gap) || (state == S_DRAIN);
  assign imem_addr   = (state == S_DRAIN) ? drain_addr : pc;
  assign instr_valid = (state == S_OUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      drain_addr   <= 32'h0;
      instr        <= 32'h0;
      instr_pc     <= 32'h0;
      req_gap      <= 1'b1;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      drain_addr   <= drain_addr_n;
      instr        <= instr_n;
      instr_pc     <= instr_pc_n;
      req_gap      <= req_gap_n;
      misalign_err <= redirect && misaligned;
    end
  end

  // A redirect always overrides sequential pc+4 advance. An in-flight
  // request that cannot complete this cycle parks in DRAIN on the old address.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    drain_addr_n = drain_addr;
    instr_n      = instr;
    instr_pc_n   = instr_pc;
    req_gap_n    = 1'b0;
    case (state)
      S_REQ: begin
        if (redirect) begin
          pc_n = target;
          if (imem_req && !imem_ready) begin
            state_n      = S_DRAIN;
            drain_addr_n = pc;
          end else if (imem_req) begin
            req_gap_n = 1'b1;
          end
        end else if (imem_req && imem_ready) begin
          instr_n    = imem_rdata;
          instr_pc_n = pc;
          state_n    = S_OUT;
        end
      end
      S_OUT: begin
        if (redirect) begin
          pc_n    = target;
          state_n = S_REQ;
        end else if (instr_ready) begin
          pc_n    = seq_pc;
          state_n = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect) pc_n = target;
        if (imem_ready) state_n = S_REQ;
      end
      default: state_n = S_REQ;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic checked against an instruction-stream reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        ctrl_valid;
  logic [31:0] ctrl_pc;
  logic [1:0]  jmp_pc;
  logic        b_pc;
  logic        branch_cond;
  logic [31:0] imm;
  logic [31:0] alu_result;
  logic        misalign_err;

  int          checks = 0;
  int          errors = 0;

  logic [31:0] model_pc;
  logic        exp_mis;
  logic        hold_expect;
  logic [31:0] held_instr;
  logic [31:0] held_pc;
  int          idle_cycles;
  logic [31:0] saved_addr;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .ctrl_valid   (ctrl_valid),
    .ctrl_pc      (ctrl_pc),
    .jmp_pc       (jmp_pc),
    .b_pc         (b_pc),
    .branch_cond  (branch_cond),
    .imm          (imm),
    .alu_result   (alu_result),
    .misalign_err (misalign_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h0050_0093;
    return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock cycle, called at a falling edge: checks the outputs, drives the
  // inputs, advances the stream model for the coming rising edge.
  task automatic applyStimulus(input logic mr, input logic dr, input logic cv,
                               input logic [1:0] jp, input logic bp, input logic bc,
                               input logic [31:0] cpc, input logic [31:0] im,
                               input logic [31:0] alu);
    logic        redir;
    logic [31:0] dest;
    checkOutput("misalign_err", {31'h0, misalign_err}, {31'h0, exp_mis});
    if (imem_req) checkOutput("addr_aligned", {30'h0, imem_addr[1:0]}, 32'h0);
    if (hold_expect) begin
      checkOutput("hold_valid", {31'h0, instr_valid}, 32'h1);
      checkOutput("hold_instr", instr, held_instr);
      checkOutput("hold_pc", instr_pc, held_pc);
    end
    imem_ready  = mr;
    instr_ready = dr;
    ctrl_valid  = cv;
    jmp_pc      = jp;
    b_pc        = bp;
    branch_cond = bc;
    ctrl_pc     = cpc;
    imm         = im;
    alu_result  = alu;
    redir = cv && (jp == 2'b01 || jp == 2'b10 || (bp && bc));
    dest  = (jp == 2'b10) ? {alu[31:1], 1'b0} : cpc + im;
    if (redir) begin
      model_pc    = {dest[31:2], 2'b00};
      idle_cycles = 0;
    end else if (instr_valid && dr) begin
      checkOutput("stream_pc", instr_pc, model_pc);
      checkOutput("stream_instr", instr, mem_word(model_pc));
      model_pc    = model_pc + 32'd4;
      idle_cycles = 0;
    end else begin
      idle_cycles++;
    end
    hold_expect = instr_valid && !dr && !redir;
    held_instr  = instr;
    held_pc     = instr_pc;
    @(negedge clk);
    exp_mis = redir && (dest[1:0] != 2'b00);
  endtask

  task automatic idleCycle(input logic mr, input logic dr);
    applyStimulus(mr, dr, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic waitValid();
    int n = 0;
    while (!instr_valid && n < 30) begin
      idleCycle(1'b1, 1'b0);
      n++;
    end
    if (!instr_valid) checkOutput("wait_valid_timeout", 32'h0, 32'h1);
  endtask

  task automatic doReset();
    reset       = 1'b1;
    hold_expect = 1'b0;
    exp_mis     = 1'b0;
    model_pc    = 32'h0;
    idle_cycles = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    imem_ready = 0; instr_ready = 0; ctrl_valid = 0; jmp_pc = 0; b_pc = 0;
    branch_cond = 0; ctrl_pc = 0; imm = 0; alu_result = 0;
    doReset();
    checkOutput("rst_req", {31'h0, imem_req}, 32'h0);
    checkOutput("rst_valid", {31'h0, instr_valid}, 32'h0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_instr_pc", instr_pc, 32'h0);
    checkOutput("rst_misalign", {31'h0, misalign_err}, 32'h0);
    reset = 1'b0;
    checkOutput("req_low_at_release", {31'h0, imem_req}, 32'h0);

    // Zero-wait memory, decoder always ready: addresses 0,4,8.
    idleCycle(1'b1, 1'b1);
    checkOutput("first_req", {31'h0, imem_req}, 32'h1);
    checkOutput("first_addr", imem_addr, 32'h0);
    idleCycle(1'b1, 1'b1);
    checkOutput("first_valid", {31'h0, instr_valid}, 32'h1);
    checkOutput("first_instr", instr, 32'h0050_0093);
    checkOutput("first_pc", instr_pc, 32'h0);
    idleCycle(1'b1, 1'b1);
    checkOutput("addr_4", imem_addr, 32'h4);
    idleCycle(1'b1, 1'b1);
    idleCycle(1'b1, 1'b1);
    checkOutput("addr_8", imem_addr, 32'h8);

    // Decoder stall for five cycles: no new request while holding.
    waitValid();
    for (int i = 0; i < 5; i++) begin
      idleCycle(1'b1, 1'b0);
      checkOutput("stall_no_req", {31'h0, imem_req}, 32'h0);
    end
    saved_addr = instr_pc;
    idleCycle(1'b0, 1'b1);
    checkOutput("after_stall_addr", imem_addr, saved_addr + 32'd4);

    // JAL from OUT with negative offset.
    waitValid();
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 32'h100, 32'hFFFF_FFF0, 32'h0);
    checkOutput("jal_valid_drop", {31'h0, instr_valid}, 32'h0);
    checkOutput("jal_addr", imem_addr, 32'hF0);

    // JALR to a misaligned address, then taken and not-taken branches.
    waitValid();
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0, 32'h203);
    checkOutput("jalr_addr", imem_addr, 32'h200);
    waitValid();
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 32'h40, 32'h8, 32'h0);
    checkOutput("branch_addr", imem_addr, 32'h48);
    waitValid();
    saved_addr = instr_pc;
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 32'h40, 32'h8, 32'h0);
    checkOutput("no_branch_addr", imem_addr, saved_addr + 32'd4);

    // Redirect while the memory stalls: old address held, stale data dropped.
    waitValid();
    idleCycle(1'b0, 1'b1);
    saved_addr = imem_addr;
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      checkOutput("drain_req", {31'h0, imem_req}, 32'h1);
      checkOutput("drain_addr", imem_addr, saved_addr);
      idleCycle(1'b0, 1'b0);
    end
    idleCycle(1'b1, 1'b0);
    checkOutput("post_drain_addr", imem_addr, 32'h300);
    waitValid();
    checkOutput("post_drain_pc", instr_pc, 32'h300);

    // PC wraparound from the top of the address space.
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h0);
    waitValid();
    checkOutput("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    idleCycle(1'b0, 1'b1);
    checkOutput("wrap_addr", imem_addr, 32'h0);

    // Reset asserted while draining.
    waitValid();
    idleCycle(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h500, 32'h0, 32'h0);
    checkOutput("pre_reset_req", {31'h0, imem_req}, 32'h1);
    #2 reset = 1'b1;
    #1 checkOutput("reset_req_drop", {31'h0, imem_req}, 32'h0);
    checkOutput("reset_valid_drop", {31'h0, instr_valid}, 32'h0);
    doReset();
    reset = 1'b0;
    waitValid();
    checkOutput("restart_pc", instr_pc, 32'h0);

    // Random traffic against the stream model.
    for (int i = 0; i < 600; i++) begin
      logic        cv;
      logic [31:0] im;
      cv = ($urandom_range(0, 9) < 2);
      im = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 255)) - 128);
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, cv,
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom, im, $urandom);
      if (idle_cycles > 40) begin
        checkOutput("watchdog", 32'h0, 32'h1);
        idle_cycles = 0;
      end
    end
    idleCycle(1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
